prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Upstream driver of the 3BC processor core: runs NUM_PROGS programs back to back.
//  Drives the core's Start input, waits for its Ack (done) flag, and times each program.
//  Flags a hung program via a timeout.
//  Sits between the bench/top-level control and the processor; the processor's Ack feeds straight back here.
// PARAMETERS
//  NUM_PROGS    3     programs per sequence; ProgIdx counts 0..NUM_PROGS-1
//  START_CYCLES 2     cycles Start is held high per launch (>=1)
//  TIMEOUT      4096  max cycles per program, counted from Start falling to Ack
//  CNT_W        16    width of cycle counters; TIMEOUT < 2**CNT_W
// PORTS
//  Clk         in   1      clock, posedge only
//  Reset       in   1      synchronous, active-high reset
//  Go          in   1      begin a sequence; sampled only in IDLE
//  Ack         in   1      processor done flag (combinational from its decoder)
//  Start       out  1      processor start/next-program request
//  ProgIdx     out  2      index of program currently/last run ($clog2(NUM_PROGS) wide)
//  CycleCt     out  CNT_W  cycle count of last completed program
//  CycleVld    out  1      1-cycle pulse when CycleCt updates
//  TimedOut    out  1      sticky; set when a program exceeds TIMEOUT
//  AllDone     out  1      high in DONE state
// BEHAVIOUR
//  Reset (sync, active high):
//   - state=IDLE; Start=0, ProgIdx=0, CycleCt=0, CycleVld=0, TimedOut=0, AllDone=0.
//   - Reset mid-sequence aborts at the next edge; no CycleVld is issued.
//  IDLE:
//   - On Go=1, go to LAUNCH with ProgIdx=0; clear TimedOut and the counter.
//  LAUNCH:
//   - Start=1 for exactly START_CYCLES cycles, then ARM. Ack is ignored here.
//  ARM:
//   - Start=0. Wait for Ack=0; a stale Ack from the previous halt is not accepted.
//   - When Ack=0, go to RUN.
//   - The counter runs from the first ARM cycle (cnt=1).
//  RUN:
//   - The counter increments each cycle.
//   - On Ack=1, go to REC (Ack is level-sampled; a 1-cycle pulse suffices).
//  REC (1 cycle):
//   - CycleCt<=cnt; CycleVld=1 for that cycle.
//   - If ProgIdx==NUM_PROGS-1, go to DONE; else ProgIdx++, counter cleared, go to LAUNCH.
//  DONE:
//   - AllDone=1 and held. Go=1 clears AllDone and returns to IDLE behaviour next cycle (restart).
//  Timeout:
//   - In ARM/RUN, if cnt==TIMEOUT with no Ack: set TimedOut, CycleCt<=TIMEOUT, pulse CycleVld.
//   - Then go to DONE without launching the remaining programs.
//   - Ack and timeout in the same cycle: Ack wins, no TimedOut.
//  Counter saturates at 2**CNT_W-1; it never wraps.
//  Go while not IDLE/DONE is ignored. Outputs are registered; Start has no combinational path from Ack.
// CONFIGURATION
//  PERF_LOG_EN defined:
//   - Adds ports LogIdx (in, ProgIdx width) and LogCt (out, CNT_W).
//   - Each REC also writes cnt into a NUM_PROGS-entry register array at ProgIdx.
//   - LogCt = array[LogIdx], combinational read. Array is cleared by Reset and by Go from IDLE/DONE.
//   - A timed-out program logs TIMEOUT.
//  PERF_LOG_EN undefined: no array and no extra ports; all other behaviour identical.
// STRUCTURE
//  Package seq_pkg:
//   - typedef enum logic[2:0] {IDLE,LAUNCH,ARM,RUN,REC,DONE} seq_state_t
//   - default constants for NUM_PROGS, START_CYCLES and TIMEOUT.
//  Sub-module sat_counter (CNT_W param; inputs Clr, En; output Q, saturating).
//   - Used for the program cycle count and reused for the START_CYCLES launch count.
//  FSM in a single always_ff plus a next-state always_comb.
// TESTING
//  1) Reset; Go pulse; Ack model rises 10 cycles after Start falls, for 3 programs.
//     -> 3 CycleVld pulses, CycleCt=10 each, ProgIdx 0,1,2, AllDone=1.
//  2) Ack held high from before Go (stale halt), drops 2 cycles after Start falls, rises 5 later.
//     -> no early REC; CycleCt=7.
//  3) TIMEOUT=32, program 1 never acks.
//     -> TimedOut=1, CycleCt=32, AllDone=1, ProgIdx=1, no program-2 Start.
//  4) Reset asserted during RUN of program 1.
//     -> next cycle all outputs at reset values, no CycleVld; a new Go restarts at ProgIdx=0.
//  5) Ack rises on the exact cycle cnt==TIMEOUT.
//     -> treated as completion, TimedOut=0, CycleCt=TIMEOUT.
//  6) PERF_LOG_EN, acks after 4, 9, 15 cycles.
//     -> LogIdx=0,1,2 reads LogCt=4, 9, 15; Go from DONE reads 0 before any new REC.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding, default parameters and a width helper shared by prog_sequencer.
package seq_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, REC, DONE} seq_state_t;

    localparam int DEF_NUM_PROGS    = 3;
    localparam int DEF_START_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 4096;
    localparam int DEF_CNT_W        = 16;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    output logic [CNT_W-1:0] Q
);

    // Clear has priority over counting; holding at all-ones keeps a hung program from looking fast.
    always_ff @(posedge Clk) begin
        if (Reset || Clr) begin
            Q <= '0;
        end else if (En && (Q != '1)) begin
            Q <= Q + 1'b1;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches NUM_PROGS programs on the core, times each one and flags hangs.
// Optional PERF_LOG_EN adds a per-program cycle log readable through LogIdx/LogCt.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS    = DEF_NUM_PROGS,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W,
    localparam int IDX_W       = idxWidth(NUM_PROGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Ack,
    output logic             Start,
    output logic [IDX_W-1:0] ProgIdx,
    output logic [CNT_W-1:0] CycleCt,
    output logic             CycleVld,
    output logic             TimedOut,
    output logic             AllDone
`ifdef PERF_LOG_EN
    ,
    input  logic [IDX_W-1:0] LogIdx,
    output logic [CNT_W-1:0] LogCt
`endif
);

    localparam int LAUNCH_W = idxWidth(START_CYCLES + 1);
    localparam logic [LAUNCH_W-1:0] LAUNCH_LAST = LAUNCH_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_CT  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_PROGS - 1);

    seq_state_t state;
    seq_state_t nextState;

    logic                goAccept;
    logic                timeoutHit;
    logic                cntClr;
    logic                cntEn;
    logic [CNT_W-1:0]    cntQ;
    logic                launchClr;
    logic                launchEn;
    logic [LAUNCH_W-1:0] launchQ;

    // The program counter holds on the Ack cycle so the recorded value excludes the halt cycle.
    assign cntEn     = (state == ARM) || ((state == RUN) && !Ack);
    assign cntClr    = (state != ARM) && (state != RUN);
    assign launchEn  = (state == LAUNCH);
    assign launchClr = (state != LAUNCH);

    sat_counter #(
        .CNT_W (CNT_W)
    ) cycleCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (cntClr),
        .En    (cntEn),
        .Q     (cntQ)
    );

    sat_counter #(
        .CNT_W (LAUNCH_W)
    ) launchCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (launchClr),
        .En    (launchEn),
        .Q     (launchQ)
    );

    // Next-state logic; in ARM an Ack is still the previous halt, so only a hang can end it early.
    always_comb begin
        nextState  = state;
        goAccept   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Go) begin
                    nextState = LAUNCH;
                    goAccept  = 1'b1;
                end
            end
            LAUNCH: begin
                if (launchQ == LAUNCH_LAST) begin
                    nextState = ARM;
                end
            end
            ARM: begin
                if (cntQ == TIMEOUT_CT) begin
                    nextState  = DONE;
                    timeoutHit = 1'b1;
                end else if (!Ack) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (Ack) begin
                    nextState = REC;
                end else if (cntQ == TIMEOUT_CT) begin
                    nextState  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            REC: begin
                nextState = (ProgIdx == LAST_IDX) ? DONE : LAUNCH;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // All outputs come from next-state decode so they line up with the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Start    <= 1'b0;
            ProgIdx  <= '0;
            CycleCt  <= '0;
            CycleVld <= 1'b0;
            TimedOut <= 1'b0;
            AllDone  <= 1'b0;
        end else begin
            state    <= nextState;
            Start    <= (nextState == LAUNCH);
            AllDone  <= (nextState == DONE);
            CycleVld <= (nextState == REC) || timeoutHit;

            if (goAccept) begin
                ProgIdx <= '0;
            end else if ((state == REC) && (nextState == LAUNCH)) begin
                ProgIdx <= ProgIdx + 1'b1;
            end

            if (goAccept) begin
                TimedOut <= 1'b0;
            end else if (timeoutHit) begin
                TimedOut <= 1'b1;
            end

            if (timeoutHit) begin
                CycleCt <= TIMEOUT_CT;
            end else if (nextState == REC) begin
                CycleCt <= cntQ;
            end
        end
    end

`ifdef PERF_LOG_EN
    logic [CNT_W-1:0] logArr [NUM_PROGS];

    // Log entries are written on the same edge that updates CycleCt.
    always_ff @(posedge Clk) begin
        if (Reset || goAccept) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                logArr[i] <= '0;
            end
        end else if (timeoutHit) begin
            logArr[ProgIdx] <= TIMEOUT_CT;
        end else if (nextState == REC) begin
            logArr[ProgIdx] <= cntQ;
        end
    end

    assign LogCt = (int'(LogIdx) < NUM_PROGS) ? logArr[LogIdx] : '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: table-driven program sequences plus directed stale-Ack, reset, timeout and log cases.
module tb_prog_sequencer;
    import seq_pkg::*;

    localparam int NUM_PROGS    = 3;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 32;
    localparam int CNT_W        = 16;
    localparam int IDX_W        = 2;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Go = 1'b0;
    logic             Ack = 1'b0;
    logic             Start;
    logic [IDX_W-1:0] ProgIdx;
    logic [CNT_W-1:0] CycleCt;
    logic             CycleVld;
    logic             TimedOut;
    logic             AllDone;
`ifdef PERF_LOG_EN
    logic [IDX_W-1:0] LogIdx = '0;
    logic [CNT_W-1:0] LogCt;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        bit issueGo;
        int ackDelay;
        int expCt;
        int expIdx;
        bit expLast;
    } vec_t;

    vec_t vecs[9];

    prog_sequencer #(
        .NUM_PROGS    (NUM_PROGS),
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Go       (Go),
        .Ack      (Ack),
        .Start    (Start),
        .ProgIdx  (ProgIdx),
        .CycleCt  (CycleCt),
        .CycleVld (CycleVld),
        .TimedOut (TimedOut),
        .AllDone  (AllDone)
`ifdef PERF_LOG_EN
        ,
        .LogIdx   (LogIdx),
        .LogCt    (LogCt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulseGo();
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic waitStartFall(input string name);
        int n = 0;
        while (!Start && n < 60) begin
            @(negedge Clk);
            n++;
        end
        while (Start && n < 60) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({name, "_startFallBound"}, 64'(n < 60), 64'd1);
    endtask

    // Ack goes high in the cycle where the program counter reads ackDelay, for one cycle.
    task automatic applyStimulus(input string name, input int ackDelay);
        waitStartFall(name);
        repeat (ackDelay) @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        Ack   = 1'b0;
        Go    = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        int n;
        int early;
        int startSeen;
        int expLog[3];

        vecs[0] = '{1'b1, 10, 10, 0, 1'b0};
        vecs[1] = '{1'b0, 10, 10, 1, 1'b0};
        vecs[2] = '{1'b0, 10, 10, 2, 1'b1};
        vecs[3] = '{1'b1,  1,  1, 0, 1'b0};
        vecs[4] = '{1'b0, 31, 31, 1, 1'b0};
        vecs[5] = '{1'b0,  2,  2, 2, 1'b1};
        vecs[6] = '{1'b1,  4,  4, 0, 1'b0};
        vecs[7] = '{1'b0,  9,  9, 1, 1'b0};
        vecs[8] = '{1'b0, 15, 15, 2, 1'b1};
        expLog  = '{4, 9, 15};

        // Reset values
        repeat (2) @(negedge Clk);
        checkOutput("rst_start", 64'(Start), 64'd0);
        checkOutput("rst_progIdx", 64'(ProgIdx), 64'd0);
        checkOutput("rst_cycleCt", 64'(CycleCt), 64'd0);
        checkOutput("rst_cycleVld", 64'(CycleVld), 64'd0);
        checkOutput("rst_timedOut", 64'(TimedOut), 64'd0);
        checkOutput("rst_allDone", 64'(AllDone), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Full sequences from the vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].issueGo) pulseGo();
            applyStimulus($sformatf("v%0d", i), vecs[i].ackDelay);
            checkOutput($sformatf("v%0d_vld", i), 64'(CycleVld), 64'd1);
            checkOutput($sformatf("v%0d_ct", i), 64'(CycleCt), 64'(vecs[i].expCt));
            checkOutput($sformatf("v%0d_idx", i), 64'(ProgIdx), 64'(vecs[i].expIdx));
            checkOutput($sformatf("v%0d_timedOut", i), 64'(TimedOut), 64'd0);
            @(negedge Clk);
            checkOutput($sformatf("v%0d_allDone", i), 64'(AllDone), 64'(vecs[i].expLast));
        end

`ifdef PERF_LOG_EN
        for (int i = 0; i < 3; i++) begin
            LogIdx = IDX_W'(i);
            #1;
            checkOutput($sformatf("log%0d", i), 64'(LogCt), 64'(expLog[i]));
        end
        pulseGo();
        for (int i = 0; i < 3; i++) begin
            LogIdx = IDX_W'(i);
            #1;
            checkOutput($sformatf("logClr%0d", i), 64'(LogCt), 64'd0);
        end
`endif

        // Stale Ack held across Go must not complete the first program early
        doReset();
        Ack = 1'b1;
        pulseGo();
        waitStartFall("stale");
        early = int'(CycleVld);
        repeat (2) begin
            @(negedge Clk);
            early += int'(CycleVld);
        end
        Ack = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            early += int'(CycleVld);
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        checkOutput("stale_noEarlyRec", 64'(early), 64'd0);
        checkOutput("stale_vld", 64'(CycleVld), 64'd1);
        checkOutput("stale_ct", 64'(CycleCt), 64'd7);

        // Reset in the middle of program 1
        waitStartFall("midRst");
        repeat (3) @(negedge Clk);
        checkOutput("midRst_preIdx", 64'(ProgIdx), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midRst_start", 64'(Start), 64'd0);
        checkOutput("midRst_idx", 64'(ProgIdx), 64'd0);
        checkOutput("midRst_ct", 64'(CycleCt), 64'd0);
        checkOutput("midRst_vld", 64'(CycleVld), 64'd0);
        checkOutput("midRst_allDone", 64'(AllDone), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        pulseGo();
        checkOutput("midRst_restartStart", 64'(Start), 64'd1);
        checkOutput("midRst_restartIdx", 64'(ProgIdx), 64'd0);

        // Program 1 never acknowledges
        doReset();
        pulseGo();
        applyStimulus("to_p0", 3);
        checkOutput("to_p0ct", 64'(CycleCt), 64'd3);
        waitStartFall("to_p1");
        n = 0;
        while (!CycleVld && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("to_latency", 64'(n), 64'd33);
        checkOutput("to_timedOut", 64'(TimedOut), 64'd1);
        checkOutput("to_ct", 64'(CycleCt), 64'd32);
        checkOutput("to_allDone", 64'(AllDone), 64'd1);
        checkOutput("to_idx", 64'(ProgIdx), 64'd1);
        startSeen = 0;
        repeat (8) begin
            @(negedge Clk);
            startSeen += int'(Start);
        end
        checkOutput("to_noLaunch", 64'(startSeen), 64'd0);
        checkOutput("to_allDoneHeld", 64'(AllDone), 64'd1);
        checkOutput("to_vldPulse", 64'(CycleVld), 64'd0);

        // Ack lands exactly on the timeout count: completion wins
        pulseGo();
        checkOutput("edge_goClrTimedOut", 64'(TimedOut), 64'd0);
        checkOutput("edge_goClrAllDone", 64'(AllDone), 64'd0);
        applyStimulus("edge", TIMEOUT);
        checkOutput("edge_vld", 64'(CycleVld), 64'd1);
        checkOutput("edge_ct", 64'(CycleCt), 64'(TIMEOUT));
        checkOutput("edge_timedOut", 64'(TimedOut), 64'd0);
        @(negedge Clk);
        checkOutput("edge_nextStart", 64'(Start), 64'd1);
        checkOutput("edge_nextIdx", 64'(ProgIdx), 64'd1);
        checkOutput("edge_timedOutLater", 64'(TimedOut), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
